packet_router_nport: RTL and testbench
======================================

// Module: packet_router_nport
// PURPOSE
//  Parametrised N-port byte-stream packet router, successor to the fixed 4-port switch.
//  - Accepts framed packets on one input stream and routes each by its header byte
//    into a per-port packet FIFO.
//  - Advertises queued packet lengths per port; drains one packet per receiver proceed.
//  - Adds what the 4-port switch lacks: speculative write with commit/rollback,
//    and explicit ack/drop status.
// PARAMETERS
//  N_PORTS     4   number of output ports; valid dest addresses are 1..N_PORTS
//  DATA_W      8   byte width of data_in / data_out
//  LEN_W       5   newdata_len width; max payload = 2**LEN_W-1
//  FIFO_DEPTH  32  payload bytes per port FIFO (power of 2)
//  PKT_Q       4   committed-packet length entries per port (power of 2)
// PORTS
//  clk          in   1               single clock, rising edge
//  reset        in   1               synchronous, active-high
//  bnd_plse     in   1               packet boundary: high on header byte and on last payload byte
//  data_in      in   DATA_W          input byte stream, one byte per cycle while framed
//  ack          out  1               1-cycle pulse: packet committed
//  drop         out  1               1-cycle pulse: packet discarded
//  proceed      in   N_PORTS         per-port receiver request to drain head packet
//  data_out     out  N_PORTS*DATA_W  per-port output byte
//  data_valid   out  N_PORTS         per-port data_out qualifier
//  newdata_len  out  N_PORTS*LEN_W   per-port head packet length, 0 = nothing queued
// BEHAVIOUR
//  Reset: FSM to IDLE, all pointers/counters 0.
//  - Reset outputs: ack=0, drop=0, data_out=0, data_valid=0, newdata_len=0.
//  - Partial and queued packets are lost, including mid-stream reset.
//  Input FSM, states IDLE / PAYLOAD / DISCARD:
//  - IDLE + bnd_plse: the data_in byte is the header.
//    - Header is valid when dest = data_in in 1..N_PORTS and that port's length queue
//      is not full; valid -> PAYLOAD, else -> DISCARD.
//    - On entry to PAYLOAD: byte count=0; speculative write pointer = committed write pointer.
//  - PAYLOAD: each cycle writes data_in at the speculative pointer, count+1.
//    - bnd_plse on a payload byte marks it the last byte (included).
//    - Last byte: commit spec pointer, push count into length queue, ack=1 next cycle, -> IDLE.
//    - Byte arriving with FIFO full, or count already 2**LEN_W-1 without bnd_plse:
//      roll back spec pointer, -> DISCARD.
//  - DISCARD: ignore bytes until bnd_plse, then drop=1 next cycle, -> IDLE.
//  - Outside a frame (IDLE without bnd_plse), data_in is ignored.
//  - Back-to-back packets are allowed: a header may arrive the cycle after a last byte.
//  Output, per port, independent:
//  - newdata_len = head of length queue, else 0.
//  - proceed sampled at edge k with port idle and newdata_len!=0:
//    - length entry is popped; data_valid=1 for cycles k+1..k+len with bytes in FIFO order.
//    - newdata_len shows the next entry from k+1.
//  - proceed while streaming or with newdata_len=0 is ignored; data_out=0 when !data_valid.
//  - Commit and pop on the same port in the same cycle are both honoured:
//    - pop uses the pre-commit head; an empty queue shows the new length the cycle after commit.
//  - Write and read of the same FIFO in the same cycle are legal.
//  - Full is computed against read ptr vs spec ptr, so uncommitted bytes count as occupancy.
//  Widths: pointers log2(depth)+1 bits, wrap naturally; count saturates-check before increment.
// STRUCTURE
//  Package router_pkg:
//  - state_e {IDLE,PAYLOAD,DISCARD}
//  - default parameter constants
//  - dest_valid() function
//  Sub-module router_port_fifo, generated N_PORTS times, holds:
//  - byte RAM, committed and spec write pointers, read pointer
//  - length queue and drain counter
//  Top holds: input FSM, count, dest decode, ack/drop registers.
// TESTING
//  1 hdr=2, payload A0..A4 (bnd_plse on A4) -> ack @+1; newdata_len[2]=5; proceed[2] -> A0..A4 on port2, 5 cycles
//  2 hdr=0 then hdr=5 (N=4), 3 bytes each -> drop pulse after each, no ack, all newdata_len stay 0
//  3 32-byte payload to port1 (exceeds 31) -> drop; next 3-byte packet to port1 -> newdata_len[1]=3
//  4 fill port3 with 28 bytes, send 6-byte packet -> drop, FIFO content and newdata_len unchanged (rollback)
//  5 packets to ports 1 and 4 back-to-back, proceed[1] and proceed[4] same cycle -> both stream concurrently
//  6 reset asserted mid-payload and mid-drain -> all outputs 0 next cycle; fresh packet then routes normally

Source files
------------

// File: rtl/router_pkg.sv
// Shared types, default sizing and header decode for the N-port packet router.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DISCARD = 2'd2
  } state_e;

  localparam int unsigned N_PORTS_DEF    = 4;
  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned LEN_W_DEF      = 5;
  localparam int unsigned FIFO_DEPTH_DEF = 32;
  localparam int unsigned PKT_Q_DEF      = 4;

  // Destination addresses are 1-based; 0 and anything above the port count are rejected.
  function automatic logic dest_valid(input logic [31:0] hdr, input int unsigned n_ports);
    return (hdr >= 32'd1) && (hdr <= n_ports);
  endfunction

endpackage

// File: rtl/router_port_fifo.sv
// One output port: payload byte RAM with speculative/committed write pointers,
// a queue of committed packet lengths, and a drain engine that streams one
// packet per accepted proceed request.
module router_port_fifo
  import router_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LEN_W      = LEN_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned PKT_Q      = PKT_Q_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              commit_i,
  input  logic [LEN_W-1:0]  commit_len_i,
  input  logic              rollback_i,
  input  logic              proceed_i,
  output logic              full_o,
  output logic              lq_full_o,
  output logic [DATA_W-1:0] data_out_o,
  output logic              data_valid_o,
  output logic [LEN_W-1:0]  newdata_len_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned QA = $clog2(PKT_Q);
  localparam int unsigned QP = QA + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [LEN_W-1:0]  lq_q  [PKT_Q];

  logic [PW-1:0]     spec_q, com_q, rd_q;
  logic [QP-1:0]     lq_wr_q, lq_rd_q;
  logic [LEN_W-1:0]  drain_q;
  logic [DATA_W-1:0] dout_q;
  logic              dv_q;

  logic [PW-1:0]     occ;
  logic [QP-1:0]     lq_occ;
  logic              lq_empty;
  logic [LEN_W-1:0]  head_len;
  logic              pop;

  // Occupancy counts uncommitted bytes too, so a packet in flight can never overrun unread data.
  assign occ       = spec_q - rd_q;
  assign full_o    = (occ == PW'(FIFO_DEPTH));
  assign lq_occ    = lq_wr_q - lq_rd_q;
  assign lq_full_o = (lq_occ == QP'(PKT_Q));
  assign lq_empty  = (lq_wr_q == lq_rd_q);
  assign head_len  = lq_q[lq_rd_q[QA-1:0]];
  assign pop       = proceed_i && (drain_q == '0) && !lq_empty;

  assign newdata_len_o = lq_empty ? '0 : head_len;
  assign data_out_o    = dout_q;
  assign data_valid_o  = dv_q;

  // Write side: speculative pointer advances per byte, committed pointer catches up on the last byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      spec_q <= '0;
      com_q  <= '0;
    end else begin
      if (start_i || rollback_i) begin
        spec_q <= com_q;
      end else if (wr_en_i) begin
        spec_q <= spec_q + PW'(1);
      end
      if (commit_i) begin
        com_q <= spec_q + PW'(1);
      end
    end
  end

  // Payload RAM; contents are don't-care until covered by a committed length entry.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[spec_q[AW-1:0]] <= wr_data_i;
    end
  end

  // Length queue pointers; push on commit, pop on an accepted proceed, both allowed together.
  always_ff @(posedge clk) begin
    if (reset) begin
      lq_wr_q <= '0;
      lq_rd_q <= '0;
    end else begin
      if (commit_i) begin
        lq_wr_q <= lq_wr_q + QP'(1);
      end
      if (pop) begin
        lq_rd_q <= lq_rd_q + QP'(1);
      end
    end
  end

  // Length queue storage.
  always_ff @(posedge clk) begin
    if (commit_i) begin
      lq_q[lq_wr_q[QA-1:0]] <= commit_len_i;
    end
  end

  // Drain engine: drain_q holds the bytes still to be shown, including the one on data_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      drain_q <= '0;
      dv_q    <= 1'b0;
      dout_q  <= '0;
      rd_q    <= '0;
    end else if (pop) begin
      drain_q <= head_len;
      dv_q    <= 1'b1;
      dout_q  <= mem_q[rd_q[AW-1:0]];
      rd_q    <= rd_q + PW'(1);
    end else if (drain_q > LEN_W'(1)) begin
      drain_q <= drain_q - LEN_W'(1);
      dout_q  <= mem_q[rd_q[AW-1:0]];
      rd_q    <= rd_q + PW'(1);
    end else if (drain_q == LEN_W'(1)) begin
      drain_q <= '0;
      dv_q    <= 1'b0;
      dout_q  <= '0;
    end
  end

endmodule

// File: rtl/packet_router_nport.sv
// N-port byte-stream packet router: header byte selects the output port,
// payload is written speculatively and committed or rolled back at the end.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | outside a frame; bnd_plse marks the header byte
//  PAYLOAD | writing payload bytes to the selected port, counting length
//  DISCARD | packet rejected; swallow bytes until the closing bnd_plse
module packet_router_nport
  import router_pkg::*;
#(
  parameter int unsigned N_PORTS    = N_PORTS_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LEN_W      = LEN_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned PKT_Q      = PKT_Q_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bnd_plse,
  input  logic [DATA_W-1:0]         data_in,
  output logic                      ack,
  output logic                      drop,
  input  logic [N_PORTS-1:0]        proceed,
  output logic [N_PORTS*DATA_W-1:0] data_out,
  output logic [N_PORTS-1:0]        data_valid,
  output logic [N_PORTS*LEN_W-1:0]  newdata_len
);

  localparam int unsigned PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  state_e            state_q, state_d;
  logic [PW-1:0]     dest_q, dest_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic              ack_q, ack_d;
  logic              drop_q, drop_d;

  logic [31:0]       hdr_ext;
  logic [PW-1:0]     hdr_idx;
  logic [LEN_W-1:0]  commit_len;

  logic [N_PORTS-1:0] start_v, wr_en_v, commit_v, rollback_v;
  logic [N_PORTS-1:0] full_v, lq_full_v;

  assign hdr_ext    = 32'(data_in);
  assign hdr_idx    = PW'(hdr_ext - 32'd1);
  assign commit_len = count_q + LEN_W'(1);

  assign ack  = ack_q;
  assign drop = drop_q;

  // Input FSM state, length count, destination and status pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dest_q  <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      count_q <= count_d;
      ack_q   <= ack_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state and per-port write strobes. A rejected byte that also closes
  // the frame goes straight back to IDLE so the next header is not swallowed.
  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    count_d    = count_q;
    ack_d      = 1'b0;
    drop_d     = 1'b0;
    start_v    = '0;
    wr_en_v    = '0;
    commit_v   = '0;
    rollback_v = '0;
    case (state_q)
      IDLE: begin
        if (bnd_plse) begin
          if (dest_valid(hdr_ext, N_PORTS) && !lq_full_v[hdr_idx]) begin
            state_d          = PAYLOAD;
            dest_d           = hdr_idx;
            count_d          = '0;
            start_v[hdr_idx] = 1'b1;
          end else begin
            state_d = DISCARD;
          end
        end
      end
      PAYLOAD: begin
        if (full_v[dest_q] || (count_q == LEN_MAX)) begin
          rollback_v[dest_q] = 1'b1;
          if (bnd_plse) begin
            drop_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DISCARD;
          end
        end else begin
          wr_en_v[dest_q] = 1'b1;
          count_d         = count_q + LEN_W'(1);
          if (bnd_plse) begin
            commit_v[dest_q] = 1'b1;
            ack_d            = 1'b1;
            state_d          = IDLE;
          end
        end
      end
      DISCARD: begin
        if (bnd_plse) begin
          drop_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    router_port_fifo #(
      .DATA_W     (DATA_W),
      .LEN_W      (LEN_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .PKT_Q      (PKT_Q)
    ) u_fifo (
      .clk           (clk),
      .reset         (reset),
      .start_i       (start_v[p]),
      .wr_en_i       (wr_en_v[p]),
      .wr_data_i     (data_in),
      .commit_i      (commit_v[p]),
      .commit_len_i  (commit_len),
      .rollback_i    (rollback_v[p]),
      .proceed_i     (proceed[p]),
      .full_o        (full_v[p]),
      .lq_full_o     (lq_full_v[p]),
      .data_out_o    (data_out[p*DATA_W +: DATA_W]),
      .data_valid_o  (data_valid[p]),
      .newdata_len_o (newdata_len[p*LEN_W +: LEN_W])
    );
  end

endmodule

// File: tb/tb_packet_router_nport.sv
// Directed bench for packet_router_nport with default parameters (4 ports).
module tb_packet_router_nport;

  logic        clk = 1'b0;
  logic        reset;
  logic        bnd_plse;
  logic [7:0]  data_in;
  logic        ack;
  logic        drop;
  logic [3:0]  proceed;
  logic [31:0] data_out;
  logic [3:0]  data_valid;
  logic [19:0] newdata_len;

  int checks = 0;
  int errors = 0;

  packet_router_nport dut (
    .clk         (clk),
    .reset       (reset),
    .bnd_plse    (bnd_plse),
    .data_in     (data_in),
    .ack         (ack),
    .drop        (drop),
    .proceed     (proceed),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .newdata_len (newdata_len)
  );

  always #5 clk = ~clk;

  // Port numbers below are 1-based, matching header addresses.
  function automatic logic [7:0] dout_p(input int p);
    return data_out[(p-1)*8 +: 8];
  endfunction

  function automatic logic dv_p(input int p);
    return data_valid[p-1];
  endfunction

  function automatic logic [4:0] nlen_p(input int p);
    return newdata_len[(p-1)*5 +: 5];
  endfunction

  // Header then len payload bytes base, base+1, ...; close puts bnd_plse on the last byte.
  task automatic send_pkt(input int hdr, input int len, input int base, input bit close);
    @(negedge clk);
    bnd_plse = 1'b1;
    data_in  = 8'(hdr);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      data_in  = 8'(base + i);
      bnd_plse = close && (i == len - 1);
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    bnd_plse = 1'b0;
    data_in  = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %0b exp 0", ack); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL rst_drop got %0b exp 0", drop); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rst_data_out got %h exp 0", data_out); end
    checks++; if (data_valid !== 4'h0) begin errors++; $display("FAIL rst_data_valid got %b exp 0", data_valid); end
    checks++; if (newdata_len !== 20'h0) begin errors++; $display("FAIL rst_newdata_len got %h exp 0", newdata_len); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    send_pkt(2, 5, 8'hA0, 1'b1);
    idle_in();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL basic_ack got %0b exp 1", ack); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL basic_drop got %0b exp 0", drop); end
    checks++; if (nlen_p(2) !== 5'd5) begin errors++; $display("FAIL basic_len2 got %0d exp 5", nlen_p(2)); end
    checks++; if (nlen_p(1) !== 5'd0) begin errors++; $display("FAIL basic_len1 got %0d exp 0", nlen_p(1)); end
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL basic_ack_pulse got %0b exp 0", ack); end
    proceed = 4'b0010;
    @(negedge clk);
    proceed = 4'b0000;
    checks++; if (nlen_p(2) !== 5'd0) begin errors++; $display("FAIL basic_len_after_pop got %0d exp 0", nlen_p(2)); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (dv_p(2) !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got %0b exp 1", i, dv_p(2)); end
      checks++; if (dout_p(2) !== 8'(8'hA0 + i)) begin errors++; $display("FAIL basic_byte[%0d] got %h exp %h", i, dout_p(2), 8'(8'hA0 + i)); end
      @(negedge clk);
    end
    checks++; if (data_valid !== 4'h0) begin errors++; $display("FAIL basic_valid_end got %b exp 0", data_valid); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL basic_dout_end got %h exp 0", data_out); end
  endtask

  task automatic test_bad_dest();
    send_pkt(0, 3, 8'h11, 1'b1);
    idle_in();
    checks++; if (drop !== 1'b1) begin errors++; $display("FAIL hdr0_drop got %0b exp 1", drop); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL hdr0_ack got %0b exp 0", ack); end
    @(negedge clk);
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL hdr0_drop_pulse got %0b exp 0", drop); end
    send_pkt(5, 3, 8'h21, 1'b1);
    idle_in();
    checks++; if (drop !== 1'b1) begin errors++; $display("FAIL hdr5_drop got %0b exp 1", drop); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL hdr5_ack got %0b exp 0", ack); end
    checks++; if (newdata_len !== 20'h0) begin errors++; $display("FAIL baddest_lens got %h exp 0", newdata_len); end
    proceed = 4'b1111;
    @(negedge clk);
    proceed = 4'b0000;
    checks++; if (data_valid !== 4'h0) begin errors++; $display("FAIL empty_proceed_valid got %b exp 0", data_valid); end
  endtask

  task automatic test_overflow();
    send_pkt(1, 32, 8'h00, 1'b1);
    idle_in();
    checks++; if (drop !== 1'b1) begin errors++; $display("FAIL ovf_drop got %0b exp 1", drop); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ovf_ack got %0b exp 0", ack); end
    checks++; if (nlen_p(1) !== 5'd0) begin errors++; $display("FAIL ovf_len1 got %0d exp 0", nlen_p(1)); end
    send_pkt(1, 3, 8'h50, 1'b1);
    idle_in();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ovf_next_ack got %0b exp 1", ack); end
    checks++; if (nlen_p(1) !== 5'd3) begin errors++; $display("FAIL ovf_next_len got %0d exp 3", nlen_p(1)); end
    proceed = 4'b0001;
    @(negedge clk);
    proceed = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      checks++; if (dout_p(1) !== 8'(8'h50 + i) || dv_p(1) !== 1'b1) begin errors++; $display("FAIL ovf_byte[%0d] got %h/%0b exp %h/1", i, dout_p(1), dv_p(1), 8'(8'h50 + i)); end
      @(negedge clk);
    end
    checks++; if (dv_p(1) !== 1'b0) begin errors++; $display("FAIL ovf_valid_end got %0b exp 0", dv_p(1)); end
  endtask

  task automatic test_rollback();
    send_pkt(3, 28, 8'h40, 1'b1);
    idle_in();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rb_fill_ack got %0b exp 1", ack); end
    checks++; if (nlen_p(3) !== 5'd28) begin errors++; $display("FAIL rb_fill_len got %0d exp 28", nlen_p(3)); end
    send_pkt(3, 6, 8'h80, 1'b1);
    idle_in();
    checks++; if (drop !== 1'b1) begin errors++; $display("FAIL rb_drop got %0b exp 1", drop); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rb_ack got %0b exp 0", ack); end
    checks++; if (nlen_p(3) !== 5'd28) begin errors++; $display("FAIL rb_len got %0d exp 28", nlen_p(3)); end
    proceed = 4'b0100;
    @(negedge clk);
    proceed = 4'b0000;
    for (int i = 0; i < 28; i++) begin
      checks++; if (dout_p(3) !== 8'(8'h40 + i) || dv_p(3) !== 1'b1) begin errors++; $display("FAIL rb_byte[%0d] got %h/%0b exp %h/1", i, dout_p(3), dv_p(3), 8'(8'h40 + i)); end
      @(negedge clk);
    end
    checks++; if (dv_p(3) !== 1'b0) begin errors++; $display("FAIL rb_valid_end got %0b exp 0", dv_p(3)); end
    checks++; if (nlen_p(3) !== 5'd0) begin errors++; $display("FAIL rb_len_end got %0d exp 0", nlen_p(3)); end
  endtask

  task automatic test_lq_full();
    for (int k = 0; k < 4; k++) begin
      send_pkt(2, 1, 8'h60 + k, 1'b1);
    end
    idle_in();
    checks++; if (nlen_p(2) !== 5'd1) begin errors++; $display("FAIL lq_head_len got %0d exp 1", nlen_p(2)); end
    send_pkt(2, 2, 8'h6A, 1'b1);
    idle_in();
    checks++; if (drop !== 1'b1) begin errors++; $display("FAIL lq_full_drop got %0b exp 1", drop); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL lq_full_ack got %0b exp 0", ack); end
    for (int k = 0; k < 4; k++) begin
      proceed = 4'b0010;
      @(negedge clk);
      proceed = 4'b0000;
      checks++; if (dout_p(2) !== 8'(8'h60 + k) || dv_p(2) !== 1'b1) begin errors++; $display("FAIL lq_byte[%0d] got %h/%0b exp %h/1", k, dout_p(2), dv_p(2), 8'(8'h60 + k)); end
      @(negedge clk);
    end
    checks++; if (nlen_p(2) !== 5'd0) begin errors++; $display("FAIL lq_len_end got %0d exp 0", nlen_p(2)); end
  endtask

  task automatic test_back_to_back();
    send_pkt(1, 4, 8'h10, 1'b1);
    send_pkt(4, 3, 8'h20, 1'b1);
    idle_in();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack got %0b exp 1", ack); end
    checks++; if (nlen_p(1) !== 5'd4) begin errors++; $display("FAIL b2b_len1 got %0d exp 4", nlen_p(1)); end
    checks++; if (nlen_p(4) !== 5'd3) begin errors++; $display("FAIL b2b_len4 got %0d exp 3", nlen_p(4)); end
    proceed = 4'b1001;
    @(negedge clk);
    proceed = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      checks++; if (dout_p(1) !== 8'(8'h10 + i) || dv_p(1) !== 1'b1) begin errors++; $display("FAIL b2b_p1[%0d] got %h/%0b exp %h/1", i, dout_p(1), dv_p(1), 8'(8'h10 + i)); end
      if (i < 3) begin
        checks++; if (dout_p(4) !== 8'(8'h20 + i) || dv_p(4) !== 1'b1) begin errors++; $display("FAIL b2b_p4[%0d] got %h/%0b exp %h/1", i, dout_p(4), dv_p(4), 8'(8'h20 + i)); end
      end else begin
        checks++; if (dv_p(4) !== 1'b0 || dout_p(4) !== 8'h00) begin errors++; $display("FAIL b2b_p4_end got %h/%0b exp 00/0", dout_p(4), dv_p(4)); end
      end
      @(negedge clk);
    end
    checks++; if (data_valid !== 4'h0) begin errors++; $display("FAIL b2b_valid_end got %b exp 0", data_valid); end
  endtask

  task automatic test_reset_mid();
    send_pkt(1, 6, 8'h30, 1'b1);
    send_pkt(1, 2, 8'h38, 1'b1);
    idle_in();
    checks++; if (nlen_p(1) !== 5'd6) begin errors++; $display("FAIL mid_len1 got %0d exp 6", nlen_p(1)); end
    proceed = 4'b0001;
    @(negedge clk);
    proceed = 4'b0000;
    checks++; if (dout_p(1) !== 8'h30 || dv_p(1) !== 1'b1) begin errors++; $display("FAIL mid_first_byte got %h/%0b exp 30/1", dout_p(1), dv_p(1)); end
    send_pkt(2, 2, 8'h70, 1'b0);
    @(negedge clk);
    reset    = 1'b1;
    bnd_plse = 1'b0;
    data_in  = 8'h00;
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mid_rst_ack got %0b exp 0", ack); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL mid_rst_drop got %0b exp 0", drop); end
    checks++; if (data_valid !== 4'h0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", data_valid); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL mid_rst_dout got %h exp 0", data_out); end
    checks++; if (newdata_len !== 20'h0) begin errors++; $display("FAIL mid_rst_lens got %h exp 0", newdata_len); end
    reset = 1'b0;
    send_pkt(3, 2, 8'h90, 1'b1);
    idle_in();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL fresh_ack got %0b exp 1", ack); end
    checks++; if (newdata_len !== 20'(5'd2 << 10)) begin errors++; $display("FAIL fresh_lens got %h exp %h", newdata_len, 20'(5'd2 << 10)); end
    proceed = 4'b0100;
    @(negedge clk);
    proceed = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      checks++; if (dout_p(3) !== 8'(8'h90 + i) || dv_p(3) !== 1'b1) begin errors++; $display("FAIL fresh_byte[%0d] got %h/%0b exp %h/1", i, dout_p(3), dv_p(3), 8'(8'h90 + i)); end
      @(negedge clk);
    end
    checks++; if (data_valid !== 4'h0) begin errors++; $display("FAIL fresh_valid_end got %b exp 0", data_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    bnd_plse = 1'b0;
    data_in  = 8'h00;
    proceed  = 4'b0000;
    test_reset();
    test_basic();
    test_bad_dest();
    test_overflow();
    test_rollback();
    test_lq_full();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
